// File: rtl/pixel_stream_gen.sv
// Raster pixel-stream source: one pixel per clock, active area then blanking,
// with selectable test pattern and an optional single-pixel red marker.
// All outputs are registered; state and pixel outputs update on the same edge.
module pixel_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic        marker_en,
  input  logic [10:0] marker_x,
  input  logic [10:0] marker_y,
  output logic [10:0] x_out,
  output logic [10:0] y_out,
  output logic [9:0]  R_out,
  output logic [9:0]  G_out,
  output logic [9:0]  B_out,
  output logic        pixel_valid,
  output logic        new_frame,
  output logic [15:0] frame_count
);

  localparam int CNT_W  = 20;
  localparam int VB_LEN = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam logic [10:0]      X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0]      Y_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(VB_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t           state_q, state_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             men_q, men_d;
  logic [10:0]      mx_q, mx_d, my_q, my_d;
  logic [9:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic             valid_q, valid_d;
  logic             nf_q, nf_d;
  logic [15:0]      fc_q, fc_d;
  logic             start_s;

  // Raster sequencing: next state, position, blank counter and frame start.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    men_d   = men_q;
    mx_d    = mx_q;
    my_d    = my_q;
    fc_d    = fc_q;
    nf_d    = 1'b0;
    start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          start_s = 1'b1;
        end else begin
          x_d = 11'd0;
          y_d = 11'd0;
        end
      end
      S_ACTIVE: begin
        if (x_q == X_LAST) begin
          state_d = S_HBLANK;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          x_d = x_q + 11'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = S_VBLANK;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = S_ACTIVE;
            x_d     = 11'd0;
            y_d     = y_q + 11'd1;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          if (enable) begin
            start_s = 1'b1;
          end else begin
            state_d = S_IDLE;
            x_d     = 11'd0;
            y_d     = 11'd0;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        x_d     = 11'd0;
        y_d     = 11'd0;
      end
    endcase
    // Frame start: jump to (0,0), pulse new_frame and snapshot pattern/marker settings.
    if (start_s) begin
      state_d = S_ACTIVE;
      x_d     = 11'd0;
      y_d     = 11'd0;
      nf_d    = 1'b1;
      fc_d    = fc_q + 16'd1;
      sel_d   = pattern_sel;
      men_d   = marker_en;
      mx_d    = marker_x;
      my_d    = marker_y;
    end else begin
      nf_d = 1'b0;
    end
  end

  // Pixel colour for the position selected above, using the per-frame settings.
  always_comb begin
    valid_d = (state_d == S_ACTIVE);
    r_d     = 10'd0;
    g_d     = 10'd0;
    b_d     = 10'd0;
    if (valid_d) begin
      case (sel_d)
        2'd0: begin
          r_d = 10'd0;
          g_d = 10'd0;
          b_d = 10'd0;
        end
        2'd1: begin
          r_d = x_d[9:0];
          g_d = y_d[9:0];
          b_d = 10'd0;
        end
        2'd2: begin
          r_d = (x_d[5] ^ y_d[5]) ? 10'h3FF : 10'h000;
          g_d = r_d;
          b_d = r_d;
        end
        2'd3: begin
          r_d = 10'h200;
          g_d = 10'h200;
          b_d = 10'h200;
        end
        default: begin
          r_d = 10'd0;
          g_d = 10'd0;
          b_d = 10'd0;
        end
      endcase
      // Marker overrides the pattern; off-screen coordinates simply never match.
      if (men_d && (x_d == mx_d) && (y_d == my_d)) begin
        r_d = 10'h3FF;
        g_d = 10'h000;
        b_d = 10'h000;
      end else begin
        r_d = r_d;
      end
    end else begin
      r_d = 10'd0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      x_q     <= 11'd0;
      y_q     <= 11'd0;
      cnt_q   <= {CNT_W{1'b0}};
      sel_q   <= 2'd0;
      men_q   <= 1'b0;
      mx_q    <= 11'd0;
      my_q    <= 11'd0;
      r_q     <= 10'd0;
      g_q     <= 10'd0;
      b_q     <= 10'd0;
      valid_q <= 1'b0;
      nf_q    <= 1'b0;
      fc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      men_q   <= men_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      nf_q    <= nf_d;
      fc_q    <= fc_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign R_out       = r_q;
  assign G_out       = g_q;
  assign B_out       = b_q;
  assign pixel_valid = valid_q;
  assign new_frame   = nf_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench for pixel_stream_gen: a small-raster instance (8x4 active,
// 50-cycle frame) for timing/marker/stop/reset, and a default-size instance
// for the checker pattern.
module tb_pixel_stream_gen;

  logic        clock = 1'b0;
  logic        resetN;
  logic        enable, enable_d;
  logic [1:0]  pattern_sel;
  logic        marker_en;
  logic [10:0] marker_x, marker_y;

  logic [10:0] s_x, s_y, d_x, d_y;
  logic [9:0]  s_r, s_g, s_b, d_r, d_g, d_b;
  logic        s_valid, s_nf, d_valid, d_nf;
  logic [15:0] s_fc, d_fc;

  int checks = 0;
  int errors = 0;
  int idx, vcnt, nfcnt, bad_grey;

  always #5 clock = ~clock;

  pixel_stream_gen #(.H_ACTIVE(8), .H_BLANK(2), .V_ACTIVE(4), .V_BLANK(1)) u_s (
    .clock(clock), .resetN(resetN), .enable(enable), .pattern_sel(pattern_sel),
    .marker_en(marker_en), .marker_x(marker_x), .marker_y(marker_y),
    .x_out(s_x), .y_out(s_y), .R_out(s_r), .G_out(s_g), .B_out(s_b),
    .pixel_valid(s_valid), .new_frame(s_nf), .frame_count(s_fc));

  pixel_stream_gen u_d (
    .clock(clock), .resetN(resetN), .enable(enable_d), .pattern_sel(pattern_sel),
    .marker_en(marker_en), .marker_x(marker_x), .marker_y(marker_y),
    .x_out(d_x), .y_out(d_y), .R_out(d_r), .G_out(d_g), .B_out(d_b),
    .pixel_valid(d_valid), .new_frame(d_nf), .frame_count(d_fc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit later, and accumulate small-raster statistics.
  task automatic tick();
    @(posedge clock);
    #1;
    idx++;
    if (s_valid) vcnt++;
    if (s_nf) nfcnt++;
    if (s_valid && !(s_r == 10'h200 && s_g == 10'h200 && s_b == 10'h200)) bad_grey++;
  endtask

  task automatic run_to(input int target);
    while (idx < target) tick();
  endtask

  task automatic start_frame();
    idx = -1; vcnt = 0; nfcnt = 0; bad_grey = 0;
    tick();
  endtask

  task automatic check_s_zero(input string tag);
    check({tag, "_x"}, {21'd0, s_x}, 32'd0);
    check({tag, "_y"}, {21'd0, s_y}, 32'd0);
    check({tag, "_rgb"}, {2'd0, s_r, s_g, s_b}, 32'd0);
    check({tag, "_valid"}, {31'd0, s_valid}, 32'd0);
    check({tag, "_nf"}, {31'd0, s_nf}, 32'd0);
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; enable_d = 1'b0;
    pattern_sel = 2'd0; marker_en = 1'b0; marker_x = 11'd0; marker_y = 11'd0;
    idx = 0; vcnt = 0; nfcnt = 0; bad_grey = 0;

    // Reset state
    repeat (3) tick();
    check_s_zero("rst");
    check("rst_fc", {16'd0, s_fc}, 32'd0);
    check("rst_d_fc", {16'd0, d_fc}, 32'd0);
    resetN = 1'b1;
    tick();
    check("idle_valid", {31'd0, s_valid}, 32'd0);

    // Frame 1: gradient, marker at (5,2)
    pattern_sel = 2'd1; marker_en = 1'b1; marker_x = 11'd5; marker_y = 11'd2; enable = 1'b1;
    start_frame();
    check("f1_nf", {31'd0, s_nf}, 32'd1);
    check("f1_fc", {16'd0, s_fc}, 32'd1);
    check("f1_xy", {s_x, s_y}, {11'd0, 11'd0});
    check("f1_valid", {31'd0, s_valid}, 32'd1);
    run_to(7);
    check("x7", {21'd0, s_x}, 32'd7);
    tick();
    check("hb0_valid", {31'd0, s_valid}, 32'd0);
    check("hb0_x", {21'd0, s_x}, 32'd7);
    check("hb0_rgb", {2'd0, s_r, s_g, s_b}, 32'd0);
    tick();
    check("hb1_x", {21'd0, s_x}, 32'd7);
    check("hb1_valid", {31'd0, s_valid}, 32'd0);
    run_to(24);
    check("p42_xy", {s_x, s_y}, {11'd4, 11'd2});
    check("p42_rgb", {2'd0, s_r, s_g, s_b}, {2'd0, 10'd4, 10'd2, 10'd0});
    tick();
    check("p52_marker", {2'd0, s_r, s_g, s_b}, {2'd0, 10'h3FF, 10'd0, 10'd0});
    marker_x = 11'd6; marker_y = 11'd3;
    run_to(36);
    check("p63_f1_rgb", {2'd0, s_r, s_g, s_b}, {2'd0, 10'd6, 10'd3, 10'd0});
    run_to(49);
    check("f1_vcnt", vcnt, 32'd32);
    check("f1_nfcnt", nfcnt, 32'd1);

    // Frame 2: back-to-back, marker now at (6,3)
    start_frame();
    check("f2_nf", {31'd0, s_nf}, 32'd1);
    check("f2_fc", {16'd0, s_fc}, 32'd2);
    run_to(25);
    check("p52_f2_rgb", {2'd0, s_r, s_g, s_b}, {2'd0, 10'd5, 10'd2, 10'd0});
    run_to(36);
    check("p63_f2_marker", {2'd0, s_r, s_g, s_b}, {2'd0, 10'h3FF, 10'd0, 10'd0});
    run_to(49);
    check("f2_vcnt", vcnt, 32'd32);
    check("f2_nfcnt", nfcnt, 32'd1);

    // Frame 3: drop enable at (3,1); frame completes, then idle
    start_frame();
    check("f3_fc", {16'd0, s_fc}, 32'd3);
    run_to(13);
    check("p31_xy", {s_x, s_y}, {11'd3, 11'd1});
    enable = 1'b0;
    run_to(39);
    check("vb_enter_valid", {31'd0, s_valid}, 32'd0);
    run_to(49);
    check("f3_vcnt", vcnt, 32'd32);
    check("f3_nfcnt", nfcnt, 32'd1);
    check("f3_last_vb_y", {21'd0, s_y}, 32'd3);
    tick();
    check_s_zero("stop");
    check("stop_fc", {16'd0, s_fc}, 32'd3);
    vcnt = 0; nfcnt = 0;
    repeat (60) tick();
    check("idle_vcnt", vcnt, 32'd0);
    check("idle_nfcnt", nfcnt, 32'd0);
    check("idle_fc", {16'd0, s_fc}, 32'd3);

    // Off-screen marker with grey pattern
    pattern_sel = 2'd3; marker_en = 1'b1; marker_x = 11'd100; marker_y = 11'd100; enable = 1'b1;
    start_frame();
    check("f4_nf", {31'd0, s_nf}, 32'd1);
    check("f4_fc", {16'd0, s_fc}, 32'd4);
    run_to(49);
    check("f4_vcnt", vcnt, 32'd32);
    check("f4_bad_grey", bad_grey, 32'd0);
    check("f4_nfcnt", nfcnt, 32'd1);
    start_frame();
    check("f5_nf", {31'd0, s_nf}, 32'd1);
    check("f5_fc", {16'd0, s_fc}, 32'd5);

    // Reset mid-frame at (6,3)
    run_to(36);
    check("p63_xy", {s_x, s_y}, {11'd6, 11'd3});
    resetN = 1'b0;
    tick();
    check_s_zero("mrst");
    check("mrst_fc", {16'd0, s_fc}, 32'd0);
    enable = 1'b0;
    tick();
    resetN = 1'b1;
    repeat (3) tick();
    check("post_rst_nf", {31'd0, s_nf}, 32'd0);
    check("post_rst_valid", {31'd0, s_valid}, 32'd0);
    enable = 1'b1;
    tick();
    check("reen_nf", {31'd0, s_nf}, 32'd1);
    check("reen_xy", {s_x, s_y}, {11'd0, 11'd0});
    check("reen_fc", {16'd0, s_fc}, 32'd1);
    enable = 1'b0;

    // Default-size checker pattern
    pattern_sel = 2'd2; marker_en = 1'b0; enable_d = 1'b1;
    tick();
    check("d_nf", {31'd0, d_nf}, 32'd1);
    check("d_00_rgb", {2'd0, d_r, d_g, d_b}, 32'd0);
    check("d_00_valid", {31'd0, d_valid}, 32'd1);
    enable_d = 1'b0;
    repeat (32) tick();
    check("d_320_xy", {d_x, d_y}, {11'd32, 11'd0});
    check("d_320_rgb", {2'd0, d_r, d_g, d_b}, {2'd0, 10'h3FF, 10'h3FF, 10'h3FF});
    repeat (700 - 32) tick();
    check("d_hb_valid", {31'd0, d_valid}, 32'd0);
    check("d_hb_rgb", {2'd0, d_r, d_g, d_b}, 32'd0);
    check("d_hb_x", {21'd0, d_x}, 32'd639);
    repeat (25600 - 700) tick();
    check("d_0_32_rgb", {2'd0, d_r, d_g, d_b}, {2'd0, 10'h3FF, 10'h3FF, 10'h3FF});
    repeat (32) tick();
    check("d_32_32_xy", {d_x, d_y}, {11'd32, 11'd32});
    check("d_32_32_rgb", {2'd0, d_r, d_g, d_b}, 32'd0);
    check("d_32_32_valid", {31'd0, d_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_gen.md
Name: pixel_stream_gen

Overview:
- Raster pixel-stream source driving the same x/y/RGB/newFrame interface that the capture path consumes.
- Emits one pixel per clock in raster order: active area, then horizontal and vertical blanking.
- Drives a selectable test pattern with an optional single-pixel key-colour marker, so the detector and capture FSM can be exercised on the board without the TV decoder.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- H_BLANK, 160, blank cycles per line.
- V_ACTIVE, 480, active lines per frame.
- V_BLANK, 45, blank lines per frame.

Ports:
- clock  in  1  system clock (CLOCK_50).
- resetN  in  1  reset.
- enable  in  1  run request; level-sensitive.
- pattern_sel  in  2  0 black, 1 gradient, 2 checker, 3 grey.
- marker_en  in  1  inject marker pixel.
- marker_x  in  11  marker column.
- marker_y  in  11  marker row.
- x_out  out  11  current pixel column.
- y_out  out  11  current pixel row.
- R_out  out  10  red.
- G_out  out  10  green.
- B_out  out  10  blue.
- pixel_valid  out  1  high on active pixels only.
- new_frame  out  1  one-cycle pulse on pixel (0,0) of each frame.
- frame_count  out  16  frames started since reset.

Behaviour:
- Reset: resetN is synchronous, active-low, on clock.
- While resetN=0, all outputs are 0, state is S_IDLE, and the h/v counters are 0.
- All outputs are registered. Pixel (x,y) appears one cycle after the state/counter update that selects it.
- States: S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK.
- S_IDLE:
  - Outputs are 0.
  - When enable=1 is sampled, the next cycle is S_ACTIVE with x_out=0, y_out=0, pixel_valid=1 and new_frame=1.
  - frame_count increments on that same cycle and wraps 16'hFFFF to 0.
- S_ACTIVE:
  - pixel_valid=1; x_out increments by 1 each cycle.
  - After x_out=H_ACTIVE-1, go to S_HBLANK.
- S_HBLANK:
  - Lasts exactly H_BLANK cycles. pixel_valid=0, RGB=0, x_out/y_out hold their last active values.
  - Exit when y_out<V_ACTIVE-1: S_ACTIVE with x_out=0 and y_out+1.
  - Exit when y_out=V_ACTIVE-1: S_VBLANK.
- S_VBLANK:
  - Lasts exactly V_BLANK*(H_ACTIVE+H_BLANK) cycles. pixel_valid=0, RGB=0, x/y hold.
  - Exit with enable=1: S_ACTIVE at (0,0) with new_frame=1 and frame_count+1. Frames are back-to-back with no gap cycle.
  - Exit with enable=0: S_IDLE; x/y/RGB return to 0.
- Frame period: (H_ACTIVE+H_BLANK)*(V_ACTIVE+V_BLANK) cycles, constant.
- enable dropped mid-frame: the current frame completes in full. Stopping occurs only at the VBLANK exit.
- pattern_sel, marker_en, marker_x and marker_y are latched once per frame, on the cycle that enters pixel (0,0). Changes mid-frame take effect next frame.
- Patterns (active pixels only):
  - 0: RGB=0.
  - 1: R=x[9:0], G=y[9:0], B=0.
  - 2: all channels 10'h3FF if x[5]^y[5], else 0.
  - 3: all channels 10'h200.
- Marker: when the latched marker_en=1 and (x,y) equals the latched marker coordinates, RGB={10'h3FF,10'h000,10'h000}, overriding the pattern.
  - A marker outside the active area never appears and causes no error.
- new_frame is never asserted outside pixel (0,0) and never for two consecutive cycles.
- Reset mid-frame: takes effect on the next edge. All outputs go to 0, state goes to S_IDLE, frame_count goes to 0, and no new_frame is emitted until enable is sampled again.
- Counter widths: h counter 11 bits, v counter 11 bits, VBLANK cycle counter wide enough for V_BLANK*(H_ACTIVE+H_BLANK) (20 bits at defaults).

Test Plan:
- Basic raster (H_ACTIVE=8, H_BLANK=2, V_ACTIVE=4, V_BLANK=1), enable=1 after reset:
  - exactly 32 pixel_valid cycles per 50-cycle frame;
  - x sequence 0..7, then 2 invalid cycles holding x=7;
  - new_frame pulses exactly 50 cycles apart;
  - frame_count goes 1,2,3.
- Stop at boundary, same params: drop enable at pixel (3,1) → frame finishes through VBLANK, then S_IDLE; outputs 0, no further new_frame, frame_count holds.
- Pattern/marker, pattern_sel=1, marker_en=1, marker=(5,2) →
  - pixel (4,2) gives R=4, G=2, B=0;
  - pixel (5,2) gives R=3FF, G=0, B=0;
  - marker changed to (6,3) mid-frame appears only in the next frame.
- Checker with defaults, pattern_sel=2 → (0,0)=0; (32,0)=3FF on all channels; (32,32)=0; HBLANK RGB=0.
- Reset mid-frame at pixel (6,3) → next cycle all outputs 0, frame_count=0; re-enable gives new_frame with (0,0) one cycle after enable is sampled.
- Off-screen marker (100,100) with small params → no red pixel, raster timing unchanged.
